// File: rtl/sig_mailbox.sv
// rtl/sig_mailbox.sv - firmware signature mailbox with sticky pass/fail flags and run-cycle count; optional watchdog via SIG_WATCHDOG_EN
module sig_mailbox #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0C00,
    parameter logic [31:0] PASS_CODE      = 32'hBEEF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        hit,
    input  logic        trap,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] cycles
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EVAL = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [2:0] IDX_CODE   = 3'd0;
    localparam logic [2:0] IDX_OBS    = 3'd1;
    localparam logic [2:0] IDX_GOLD   = 3'd2;
    localparam logic [2:0] IDX_STATUS = 3'd3;
    localparam logic [2:0] IDX_CYCLES = 3'd4;

`ifdef SIG_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    state_e      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [31:0] obs_q, obs_d;
    logic [31:0] gold_q, gold_d;
    logic [31:0] cycles_q, cycles_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        timeout_q, timeout_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        req;
    logic        wr_en;
    logic [2:0]  reg_idx;
    logic [31:0] status_word;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    // Word addressing only; the byte offset within a word carries no meaning here.
    assign unused_addr_bits = ^mem_addr[1:0];

    assign hit         = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    // A new request needs mem_ready low so one request is never acked twice.
    assign req         = hit && !mem_ready_q;
    // Result words freeze once the run has been judged.
    assign wr_en       = req && (mem_wstrb != 4'b0000) && (state_q != ST_HALT);
    assign reg_idx     = mem_addr[4:2];
    assign status_word = {28'd0, timeout_q, fail_q, pass_q, done_q};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    // Read mux: pre-edge register values, so a same-edge write is not reflected.
    always_comb begin
        rd_mux = 32'd0;
        case (reg_idx)
            IDX_CODE:   rd_mux = code_q;
            IDX_OBS:    rd_mux = obs_q;
            IDX_GOLD:   rd_mux = gold_q;
            IDX_STATUS: rd_mux = status_word;
            IDX_CYCLES: rd_mux = cycles_q;
            default:    rd_mux = 32'd0;
        endcase
    end

    // Bus ack and registered read data; rdata is forced to 0 outside the ack cycle.
    always_comb begin
        mem_ready_d = req;
        mem_rdata_d = req ? rd_mux : 32'd0;
    end

    // Byte-merged writes into the three result words.
    always_comb begin
        code_d = code_q;
        obs_d  = obs_q;
        gold_d = gold_q;
        if (wr_en) begin
            case (reg_idx)
                IDX_CODE: code_d = merge_bytes(code_q, mem_wdata, mem_wstrb);
                IDX_OBS:  obs_d  = merge_bytes(obs_q, mem_wdata, mem_wstrb);
                IDX_GOLD: gold_d = merge_bytes(gold_q, mem_wdata, mem_wstrb);
                default:  ;
            endcase
        end
    end

    // Run FSM: count while running, judge the code word after a trap, then halt for good.
    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (trap) begin
                    state_d = ST_EVAL;
`ifdef SIG_WATCHDOG_EN
                end else if (cycles_q == WD_LAST) begin
                    state_d   = ST_HALT;
                    cycles_d  = cycles_q + 32'd1;
                    done_d    = 1'b1;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cycles_d = cycles_q + 32'd1;
                end
`else
                end else if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
`endif
            end
            ST_EVAL: begin
                // code_q already contains any write acked on the trap edge.
                state_d = ST_HALT;
                done_d  = 1'b1;
                pass_d  = (code_q == PASS_CODE);
                fail_d  = (code_q != PASS_CODE);
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // State registers; reset clears everything and drops an in-flight ack immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            code_q      <= 32'd0;
            obs_q       <= 32'd0;
            gold_q      <= 32'd0;
            cycles_q    <= 32'd0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            obs_q       <= obs_d;
            gold_q      <= gold_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_sig_mailbox.sv
// tb/tb_sig_mailbox.sv - randomized scoreboard bench for sig_mailbox (watchdog checks when SIG_WATCHDOG_EN is defined)
module tb_sig_mailbox;

    localparam logic [31:0] BASE  = 32'h0000_0C00;
    localparam logic [31:0] PASSC = 32'hBEEF_0000;
    localparam int          TMO   = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        trap = 1'b0;
    logic        mem_ready, hit, done, pass, fail, timeout;
    logic [31:0] mem_rdata, cycles;

    always #5 clk = ~clk;

    sig_mailbox #(
        .BASE_ADDR(BASE),
        .PASS_CODE(PASSC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit(hit), .trap(trap), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .cycles(cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tb_edges;

    // Rising edges since reset release: edge N is the Nth edge of the run.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_edges <= 0;
        else     tb_edges <= tb_edges + 1;
    end

    // Reference model: result words, verdict flags, and the cycle value where counting stops.
    logic [31:0] m_reg [3];
    bit          m_halted, m_done, m_pass, m_fail, m_tmo;
    longint      m_limit;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) m_reg[i] = 32'd0;
        m_halted = 0; m_done = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
`ifdef SIG_WATCHDOG_EN
        m_limit = TMO;
`else
        m_limit = 64'h0000_0000_FFFF_FFFF;
`endif
    endfunction

    // Counter value after k edges of the run.
    function automatic logic [31:0] cyc_after(input longint k);
        return (k > m_limit) ? m_limit[31:0] : k[31:0];
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] off, input int n);
        case (off[4:2])
            3'd0, 3'd1, 3'd2: return m_reg[off[3:2]];
            3'd3:             return {28'd0, m_tmo, m_fail, m_pass, m_done};
            3'd4:             return cyc_after(n - 1);
            default:          return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
        if (!m_halted && off[4:2] < 3'd3) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_reg[off[3:2]][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic void model_trap(input int n);
        if (!m_halted) begin
            m_halted = 1;
            m_limit  = n - 1;
            m_done   = 1;
            m_pass   = (m_reg[0] == PASSC);
            m_fail   = !m_pass;
            m_tmo    = 0;
        end
    endfunction

    // Monitor: every ack pops one expectation; acks never last two cycles; rdata idles at 0.
    bit prev_ready = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mem_ready) begin
            check("ack_one_cycle", {31'd0, prev_ready}, 32'd0);
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) check("rdata", mem_rdata, e.data);
            end
        end else begin
            check("rdata_idle", mem_rdata, 32'd0);
        end
        prev_ready = mem_ready;
    end

    task automatic check_flags(input string name);
        check({name, "_flags"}, {28'd0, timeout, fail, pass, done},
              {28'd0, m_tmo, m_fail, m_pass, m_done});
    endtask

    // One in-window access; optionally raise trap for the same edge.
    task automatic bus(input logic [4:0] off, input logic [31:0] data, input logic [3:0] strb, input bit with_trap);
        exp_t e;
        int   n;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = BASE | {27'd0, off}; mem_wdata = data; mem_wstrb = strb;
        trap = with_trap;
        #1;
        check("hit", {31'd0, hit}, 32'd1);
        check("ready_before_edge", {31'd0, mem_ready}, 32'd0);
        @(posedge clk); #1;
        n = tb_edges;
        e.is_rd = (strb == 4'd0);
        e.data  = model_read(off, n);
        sb_q.push_back(e);
        if (strb != 4'd0) model_write(off, data, strb);
        if (with_trap) model_trap(n);
        @(negedge clk);
        check("ack_latency", {31'd0, mem_ready}, 32'd1);
        trap = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'd0;
    endtask

    // Request outside the window, or in-window with valid low: never hit, never acked.
    task automatic miss(input bit valid_low);
        @(negedge clk);
        mem_valid = !valid_low;
        mem_addr  = valid_low ? BASE : ((BASE ^ (32'h20 << $urandom_range(0, 26))) | {27'd0, 5'($urandom_range(0, 7) * 4)});
        mem_wstrb = 4'($urandom_range(0, 15));
        mem_wdata = $urandom;
        #1;
        check("miss_hit", {31'd0, hit}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("miss_no_ack", {31'd0, mem_ready}, 32'd0);
        mem_valid = 1'b0; mem_wstrb = 4'd0;
    endtask

    task automatic trap_pulse();
        @(negedge clk); trap = 1'b1;
        @(posedge clk); #1; model_trap(tb_edges);
        @(negedge clk); trap = 1'b0;
        check("done_not_yet", {31'd0, done}, 32'd0);
        @(negedge clk);
        check_flags("trap");
        check("cycles_frozen", cycles, cyc_after(tb_edges));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_valid = 1'b0; mem_wstrb = 4'd0; trap = 1'b0;
        @(negedge clk);
        check("rst_outputs", {mem_ready, done, pass, fail, timeout}, 32'd0);
        check("rst_cycles", cycles, 32'd0);
        sb_q.delete();
        model_reset();
        rst = 1'b0;
    endtask

    task automatic wait_edges(input int target);
        for (int i = 0; i < 2000 && tb_edges < target; i++) @(negedge clk);
        check("wait_edges_reached", tb_edges, target);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] off;
        model_reset();
        do_reset();

        // Passing signature.
        bus(5'h00, PASSC, 4'hF, 0);
        bus(5'h04, 32'd5, 4'hF, 0);
        bus(5'h08, 32'd5, 4'hF, 0);
        trap_pulse();
        bus(5'h0C, 0, 4'h0, 0);
        bus(5'h10, 0, 4'h0, 0);

        // Failing signature; OBS/GOLD readback intact.
        do_reset();
        bus(5'h04, 32'h1111_2222, 4'hF, 0);
        bus(5'h08, 32'h3333_4444, 4'hF, 0);
        bus(5'h00, 32'hDEAD_0001, 4'hF, 0);
        trap_pulse();
        bus(5'h0C, 0, 4'h0, 0);
        bus(5'h04, 0, 4'h0, 0);
        bus(5'h08, 0, 4'h0, 0);

        // Byte-strobe merge, then frozen CODE in HALT, then reset mid-transaction.
        do_reset();
        bus(5'h00, 32'hAABB_CCDD, 4'b0001, 0);
        bus(5'h00, 32'hAABB_CCDD, 4'b1100, 0);
        bus(5'h00, 0, 4'h0, 0);
        bus(5'h10, 32'hFFFF_FFFF, 4'hF, 0);
        bus(5'h14, 32'hFFFF_FFFF, 4'hF, 0);
        bus(5'h14, 0, 4'h0, 0);
        trap_pulse();
        bus(5'h00, 32'h0000_1234, 4'hF, 0);
        bus(5'h00, 0, 4'h0, 0);
        begin
            exp_t e;
            @(negedge clk);
            mem_valid = 1'b1; mem_addr = BASE | 32'h10; mem_wstrb = 4'd0;
            @(posedge clk); #1;
            e.is_rd = 1'b1; e.data = model_read(5'h10, tb_edges);
            sb_q.push_back(e);
            @(negedge clk);
            check("mid_ack", {31'd0, mem_ready}, 32'd1);
            #2 rst = 1'b1;
            #1;
            check("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
            check("mid_rst_rdata", mem_rdata, 32'd0);
            check("mid_rst_flags", {28'd0, timeout, fail, pass, done}, 32'd0);
            check("mid_rst_cycles", cycles, 32'd0);
            mem_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            sb_q.delete();
            model_reset();
            bus(5'h00, 0, 4'h0, 0);
            bus(5'h10, 0, 4'h0, 0);
        end

        // CODE write acked on the trap edge is judged.
        do_reset();
        bus(5'h00, 32'h0BAD_0BAD, 4'hF, 0);
        bus(5'h00, PASSC, 4'hF, 1);
        @(negedge clk);
        check_flags("same_edge");
        bus(5'h0C, 0, 4'h0, 0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int k = 0; k < 12; k++) begin
                int sel;
                sel = $urandom_range(0, 9);
                off = 5'($urandom_range(0, 7) * 4);
                if (sel < 4)       bus(off, 32'd0, 4'd0, 0);
                else if (sel < 9)  bus(off, $urandom, 4'($urandom_range(1, 15)), 0);
                else               miss($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 1) == 1) bus(5'h00, PASSC, 4'hF, 0);
            trap_pulse();
            for (int k = 0; k < 8; k++) bus(5'(k * 4), 32'd0, 4'd0, 0);
            bus(5'($urandom_range(0, 2) * 4), $urandom, 4'hF, 0);
            bus(5'h00, 32'd0, 4'd0, 0);
            check("halt_cycles_hold", cycles, cyc_after(tb_edges));
        end

`ifdef SIG_WATCHDOG_EN
        // Watchdog expiry with no trap.
        do_reset();
        wait_edges(TMO - 1);
        check("wd_before_done", {31'd0, done}, 32'd0);
        check("wd_before_cycles", cycles, 32'(TMO - 1));
        @(negedge clk);
        m_halted = 1; m_done = 1; m_fail = 1; m_tmo = 1;
        check_flags("wd");
        check("wd_cycles", cycles, 32'(TMO));
        @(negedge clk); trap = 1'b1;
        @(negedge clk); @(negedge clk); trap = 1'b0;
        @(negedge clk);
        check_flags("wd_after_trap");
        check("wd_cycles_hold", cycles, 32'(TMO));
        bus(5'h0C, 0, 4'h0, 0);

        // Trap on the watchdog edge wins.
        do_reset();
        bus(5'h00, PASSC, 4'hF, 0);
        wait_edges(TMO - 1);
        trap = 1'b1;
        @(posedge clk); #1; model_trap(tb_edges);
        @(negedge clk); trap = 1'b0;
        @(negedge clk);
        check_flags("wd_trap_tie");
        check("wd_trap_tie_cycles", cycles, 32'(TMO - 1));
`else
        // No watchdog: counting continues well past the limit.
        do_reset();
        wait_edges(TMO + 50);
        check("nowd_done", {28'd0, timeout, fail, pass, done}, 32'd0);
        check("nowd_cycles", cycles, cyc_after(tb_edges));
        bus(5'h10, 0, 4'h0, 0);
        trap_pulse();
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sig_mailbox.md
# sig_mailbox

Memory-mapped signature mailbox on the PicoRV32 native memory bus, the SoC-side responder for the firmware self-check signature (code/obs/gold words). Firmware stores its result words here, then executes `ebreak`. The block watches the core's `trap`, compares the code word against the pass value, and drives sticky `done`/`pass`/`fail` flags plus a run-cycle count. Benches and future FPGA LEDs read these flags instead of peeking at RAM. An optional watchdog ends a run that never traps.

## Interface
- `BASE_ADDR`, default 32'h0000_0C00: byte address of the 32-byte mailbox window; must be 32-byte aligned.
- `PASS_CODE`, default 32'hBEEF_0000: code word value that means pass.
- `TIMEOUT_CYCLES`, default 200000: watchdog limit in RUN cycles; must be at least 1.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mem_valid`  in  1  PicoRV32 request valid.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write strobes; 0 means read.
- `mem_ready`  out  1  one-cycle acknowledge for a request that hits the window.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1, otherwise 0.
- `hit`  out  1  combinational: `mem_valid` and `mem_addr[31:5]`==`BASE_ADDR[31:5]`; the SoC uses it for bus muxing.
- `trap`  in  1  PicoRV32 trap output.
- `done`  out  1  sticky: run ended.
- `pass`  out  1  sticky: run ended by trap with CODE==`PASS_CODE`.
- `fail`  out  1  sticky: run ended and not pass.
- `timeout`  out  1  sticky: run ended by watchdog.
- `cycles`  out  32  RUN-cycle counter.

## Operation
- Register map, by offset:
  - 0x00 CODE, RW.
  - 0x04 OBS, RW.
  - 0x08 GOLD, RW.
  - 0x0C STATUS, RO: bit0 done, bit1 pass, bit2 fail, bit3 timeout, other bits 0.
  - 0x10 CYCLES, RO.
  - 0x14–0x1C read as 0; writes to them are acked and ignored.
- Writes merge per byte under `mem_wstrb`. Writes to RO registers are acked and ignored.
- FSM states: RUN, EVAL, HALT. Reset state is RUN.
- RUN:
  - If `trap`=1: go to EVAL.
  - Else if `SIG_WATCHDOG_EN` and `cycles`==`TIMEOUT_CYCLES`-1: go to HALT and set done=1, fail=1, timeout=1 on the same edge.
  - Else: `cycles` increments.
- EVAL: set done=1, pass=(CODE==`PASS_CODE`), fail=!pass, then go to HALT.
- HALT: terminal until reset. CODE/OBS/GOLD are frozen; writes are acked and dropped. Reads still work. `cycles` holds.
- `trap` and the watchdog condition in the same cycle: trap wins (go to EVAL, no timeout).
- A CODE write acked on the same edge that `trap` is sampled in RUN is included in EVAL's comparison.
- `rst` asserted at any time clears all registers, flags and `cycles` to 0, sets state to RUN, and drops `mem_ready` immediately. This holds even in the middle of a bus transaction.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `done`/`pass`/`fail`/`timeout`=0, `cycles`=0, CODE/OBS/GOLD=0.
- Bus handshake:
  - A request (`hit`=1 and `mem_ready`=0) sampled at edge N gives `mem_ready`=1 for exactly the cycle after edge N, with `mem_rdata` registered.
  - The write takes effect at edge N.
  - Ack latency is 1 cycle; there is no back-to-back ack of the same request, because a new ack requires `mem_ready`=0.
- Reads return the register value as of edge N, before any same-edge write (writes occupy their own transactions, so no conflict in practice).
- Trap path: `trap` high at edge N moves the FSM to EVAL. Flags become visible after edge N+1 (2-cycle latency). `cycles` freezes at edge N.
- Watchdog flags are visible after the edge where `cycles` reaches `TIMEOUT_CYCLES`.

## Configuration
- `SIG_WATCHDOG_EN` defined:
  - Watchdog logic is compiled in as described above.
- `SIG_WATCHDOG_EN` undefined:
  - No watchdog; RUN leaves only on `trap`.
  - `timeout` is tied to 0 and STATUS bit3 reads 0.
  - `cycles` saturates at 32'hFFFF_FFFF instead of wrapping.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Write CODE=32'hBEEF_0000, OBS=5, GOLD=5, then pulse `trap` → 2 cycles later done=1, pass=1, fail=0, timeout=0; read STATUS → 32'h3.
- Write CODE=32'hDEAD_0001, then `trap` → done=1, pass=0, fail=1; STATUS reads 32'h5; readback of OBS/GOLD is unchanged.
- Byte writes to CODE with strobes 4'b0001 then 4'b1100, data 32'hAABBCCDD each → CODE reads 32'hAABB00DD; each access acked with `mem_ready` high for exactly one cycle, one cycle after valid.
- `SIG_WATCHDOG_EN` with `TIMEOUT_CYCLES`=100 and no trap → after edge 100 from reset release: cycles=100, done=1, fail=1, timeout=1; a later `trap` changes nothing.
- In HALT, write CODE=32'h1234 → acked, CODE unchanged. Assert `rst` mid-transaction → `mem_ready` drops at once, all outputs 0, FSM back in RUN.
- `trap` asserted on the same edge as the watchdog limit → pass/fail decided by CODE, timeout=0.
